// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset control unit: FSM states,
// datapath select codes, opcode classes and condition codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } ctrlState_e;

    localparam logic [1:0] ALUCTL_ADD = 2'b00;
    localparam logic [1:0] ALUCTL_SUB = 2'b01;
    localparam logic [1:0] ALUCTL_AND = 2'b10;
    localparam logic [1:0] ALUCTL_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // flags is {N,Z,C,V}; the reserved 1111 code never executes
    function automatic logic condCheck(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic result;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_MI: result = n;
            COND_PL: result = ~n;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_HI: result = c & ~z;
            COND_LS: result = ~(c & ~z);
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = ~z & (n == v);
            COND_LE: result = ~(~z & (n == v));
            COND_AL: result = 1'b1;
            default: result = 1'b0;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/controller_condlogic.sv
// Condition logic: stored NZCV flags, condition evaluation and gating of the
// architectural write enables by the registered condition result.
module condlogic
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluFlags,
    input  logic [1:0] flagW,
    input  logic       pcs,
    input  logic       nextPc,
    input  logic       regW,
    input  logic       memW,
    output logic       pcWrite,
    output logic       regWrite,
    output logic       memWrite
);

    logic [3:0] flags;
    logic       condEx;
    logic       condExReg;

    assign condEx = condCheck(cond, flags);

    // NZ and CV are written independently so logical ops leave C and V alone
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags     <= 4'b0000;
            condExReg <= 1'b0;
        end else begin
            if (flagW[1] && condEx)
                flags[3:2] <= aluFlags[3:2];
            if (flagW[0] && condEx)
                flags[1:0] <= aluFlags[1:0];
            condExReg <= condEx;
        end
    end

    assign pcWrite  = nextPc | (pcs & condExReg);
    assign regWrite = regW & condExReg;
    assign memWrite = memW & condExReg;

endmodule

// File: rtl/controller.sv
// Multicycle ARM-subset controller: main-decoder FSM and ALU decoder, with
// condition checking and write-enable gating delegated to condlogic.
module controller
    import ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    ctrlState_e state, stateNext;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unusedRn;

    logic       nextPc, branch, regW, memW, aluOp, pcs;
    logic [1:0] flagW;

    assign cond     = Instr[19:16];
    assign op       = Instr[15:14];
    assign funct    = Instr[13:8];
    assign rd       = Instr[3:0];
    assign unusedRn = ^Instr[7:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FETCH;
        else
            state <= stateNext;
    end

    always_comb begin
        stateNext = FETCH;
        case (state)
            FETCH:   stateNext = DECODE;
            DECODE: begin
                case (op)
                    OP_MEM:  stateNext = MEMADR;
                    OP_BR:   stateNext = BRANCH;
                    OP_DP:   stateNext = funct[5] ? EXECI : EXECR;
                    default: stateNext = FETCH;
                endcase
            end
            MEMADR:  stateNext = funct[0] ? MEMRD : MEMWR;
            MEMRD:   stateNext = MEMWB;
            EXECR:   stateNext = ALUWB;
            EXECI:   stateNext = ALUWB;
            default: stateNext = FETCH;
        endcase
    end

    always_comb begin
        nextPc    = 1'b0;
        branch    = 1'b0;
        regW      = 1'b0;
        memW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        aluOp     = 1'b0;
        case (state)
            FETCH: begin
                IRWrite   = 1'b1;
                nextPc    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            MEMADR:  ALUSrcB = SRCB_IMM;
            MEMRD:   AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = RES_DATA;
                regW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                memW   = 1'b1;
            end
            EXECR:   aluOp = 1'b1;
            EXECI: begin
                ALUSrcB = SRCB_IMM;
                aluOp   = 1'b1;
            end
            ALUWB:   regW = 1'b1;
            BRANCH: begin
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURESULT;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Only add and subtract produce meaningful carry/overflow
    always_comb begin
        ALUControl = ALUCTL_ADD;
        flagW      = 2'b00;
        if (aluOp) begin
            case (funct[4:1])
                4'b0100: ALUControl = ALUCTL_ADD;
                4'b0010: ALUControl = ALUCTL_SUB;
                4'b0000: ALUControl = ALUCTL_AND;
                4'b1100: ALUControl = ALUCTL_ORR;
                default: ALUControl = ALUCTL_ADD;
            endcase
            flagW[1] = funct[0];
            flagW[0] = funct[0] & ((ALUControl == ALUCTL_ADD) | (ALUControl == ALUCTL_SUB));
        end
    end

    assign pcs    = branch | (regW & (rd == 4'hF));
    assign RegSrc = {(op == OP_MEM), (op == OP_BR)};
    assign ImmSrc = op;

    condlogic uCondLogic (
        .clk      (clk),
        .reset    (reset),
        .cond     (cond),
        .aluFlags (ALUFlags),
        .flagW    (flagW),
        .pcs      (pcs),
        .nextPc   (nextPc),
        .regW     (regW),
        .memW     (memW),
        .pcWrite  (PCWrite),
        .regWrite (RegWrite),
        .memWrite (MemWrite)
    );

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the multicycle controller: an instruction-level model
// predicts each cycle's control word, a monitor compares on the falling edge.
module tb_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    always #5 clk = ~clk;

    controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl)
    );

    typedef struct {
        logic [15:0] v;
        string       tag;
    } exp_t;

    exp_t        expQ[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [3:0]  mFlags;
    logic [15:0] actVec;

    assign actVec = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                     ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    function automatic logic [15:0] mk(input logic pcw, input logic memw, input logic regw,
                                       input logic irw, input logic adr, input logic [1:0] rs,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] res,
                                       input logic [1:0] imm, input logic [1:0] alu);
        return {pcw, memw, regw, irw, adr, rs, sa, sb, res, imm, alu};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Conditions come in true/inverted pairs selected by cond[0]
    function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, base;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cond[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c & ~z;
            3'd5: base = (n == v);
            3'd6: base = ~z & (n == v);
            default: return ~cond[0];
        endcase
        return base ^ cond[0];
    endfunction

    function automatic logic [1:0] aluSel(input logic [5:0] fn);
        if (fn[4:1] == 4'b0010) return 2'b01;
        if (fn[4:1] == 4'b0000) return 2'b10;
        if (fn[4:1] == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [15:0] fetchVec(input logic [1:0] op);
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {op == 2'b01, op == 2'b10},
                  1'b1, 2'b10, 2'b10, op, 2'b00);
    endfunction

    task automatic push(input string tag, input logic [15:0] v);
        exp_t e;
        e.v = v;
        e.tag = tag;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One instruction from fetch to writeback; IR loads at the end of fetch
    task automatic runInstr(input logic [19:0] ins, input logic [3:0] af);
        logic [1:0] op, rs, alu;
        logic [5:0] fn;
        logic       c, pcs;
        ALUFlags = af;
        push("fetch", fetchVec(Instr[15:14]));
        Instr = ins;
        op  = ins[15:14];
        fn  = ins[13:8];
        c   = condHolds(ins[19:16], mFlags);
        rs  = {op == 2'b01, op == 2'b10};
        pcs = (ins[3:0] == 4'hF);
        push("decode", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rs, 1'b1, 2'b10, 2'b10, op, 2'b00));
        case (op)
            2'b01: begin
                push("memadr", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rs, 1'b0, 2'b01, 2'b00, op, 2'b00));
                if (fn[0]) begin
                    push("memrd", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rs, 1'b0, 2'b00, 2'b00, op, 2'b00));
                    push("memwb", mk(pcs & c, 1'b0, c, 1'b0, 1'b0, rs, 1'b0, 2'b00, 2'b01, op, 2'b00));
                end else begin
                    push("memwr", mk(1'b0, c, 1'b0, 1'b0, 1'b1, rs, 1'b0, 2'b00, 2'b00, op, 2'b00));
                end
            end
            2'b00: begin
                alu = aluSel(fn);
                push("exec", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rs, 1'b0, {1'b0, fn[5]}, 2'b00, op, alu));
                if (c && fn[0]) begin
                    mFlags[3:2] = af[3:2];
                    if (alu <= 2'b01) mFlags[1:0] = af[1:0];
                end
                push("aluwb", mk(pcs & c, 1'b0, c, 1'b0, 1'b0, rs, 1'b0, 2'b00, 2'b00, op, 2'b00));
            end
            2'b10: push("branch", mk(c, 1'b0, 1'b0, 1'b0, 1'b0, rs, 1'b0, 2'b01, 2'b10, op, 2'b00));
            default: ;
        endcase
    endtask

    function automatic logic [19:0] randIns();
        logic [3:0] cond, rn, rd;
        logic [1:0] op;
        logic [5:0] fn;
        int k;
        cond = ($urandom_range(0, 1) == 0) ? 4'hE : 4'($urandom_range(0, 15));
        k  = $urandom_range(0, 9);
        op = (k < 4) ? 2'b00 : (k < 7) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
        fn = 6'($urandom_range(0, 63));
        rn = 4'($urandom_range(0, 15));
        rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
        return {cond, op, fn, rn, rd};
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check(e.tag, actVec, e.v);
            end
        end
    end

    initial begin : driver
        exp_t e;
        reset    = 1'b0;
        Instr    = 20'h00000;
        ALUFlags = 4'h0;
        mFlags   = 4'h0;
        #12;
        check("reset_state", actVec, fetchVec(2'b00));
        @(posedge clk);
        #1;
        reset = 1'b1;

        runInstr(20'hE04F0, 4'h0);
        runInstr(20'hE5912, 4'h3);
        runInstr(20'hE5812, 4'h5);
        runInstr(20'hE0512, 4'b0100);
        runInstr(20'h0A000, 4'h0);
        runInstr(20'h1A000, 4'h0);

        // Set all flags, then pull reset during the next EXECR
        runInstr(20'hE0512, 4'b1111);
        ALUFlags = 4'b1010;
        push("fetch", fetchVec(Instr[15:14]));
        Instr = 20'hE0512;
        push("decode", mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10, 2'b10, 2'b00, 2'b00));
        e.v   = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01);
        e.tag = "exec_before_reset";
        expQ.push_back(e);
        #5;
        reset = 1'b0;
        #1;
        check("reset_mid_exec", actVec, fetchVec(2'b00));
        mFlags = 4'h0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        runInstr(20'h0A000, 4'h0);
        runInstr(20'h1A000, 4'h0);

        repeat (300) runInstr(randIns(), 4'($urandom_range(0, 15)));

        repeat (2) @(posedge clk);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
